// File: rtl/graph_trace_scheduler.sv
// Five-channel sample history store with a round-robin sample arbiter and a
// two-cycle pipelined pixel-hit lookup that feeds the graph colour mixer.
module graph_trace_scheduler #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned VAL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4:0]                 smp_valid,
    input  logic [5*VAL_W-1:0]         smp_data,
    output logic [4:0]                 smp_ready,
    input  logic [4:0]                 ch_en,
    input  logic                       freeze,
    input  logic                       clr,
    input  logic                       px_req,
    input  logic [$clog2(DEPTH)-1:0]   px_col,
    input  logic [VAL_W-1:0]           px_row,
    output logic                       px_valid,
    output logic [4:0]                 px_code
);

    localparam int unsigned NCH = 5;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    logic [VAL_W-1:0] mem  [NCH][DEPTH];
    logic [AW-1:0]    wptr [NCH];
    logic [CW-1:0]    cnt  [NCH];
    logic [2:0]       rr_ptr;

    logic [4:0]       eligible_c;
    logic [4:0]       grant_c;
    logic [2:0]       gnt_idx_c;
    logic             gnt_any_c;
    logic [3:0]       pos_sum_c;
    logic [2:0]       pos_c;

    logic [VAL_W-1:0] rd_data_c [NCH];
    logic [4:0]       col_ok_c;
    logic [AW-1:0]    rd_idx_c  [NCH];

    logic             s1_vld;
    logic [VAL_W-1:0] s1_data   [NCH];
    logic [4:0]       s1_ok;
    logic [VAL_W-1:0] s1_row;
    logic             s2_vld;
    logic [4:0]       s2_hit;

    // Round-robin arbiter: first eligible channel at or after rr_ptr wins.
    always_comb begin
        eligible_c = smp_valid & ch_en & {NCH{~freeze & ~clr & rst_n}};
        grant_c    = '0;
        gnt_idx_c  = '0;
        gnt_any_c  = 1'b0;
        pos_sum_c  = '0;
        pos_c      = '0;
        for (int k = 0; k < NCH; k++) begin
            pos_sum_c = 4'(rr_ptr) + 4'(k);
            if (pos_sum_c >= 4'(NCH)) pos_sum_c = pos_sum_c - 4'(NCH);
            pos_c = 3'(pos_sum_c);
            if (!gnt_any_c && eligible_c[pos_c]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = pos_c;
            end
        end
        if (gnt_any_c) grant_c[gnt_idx_c] = 1'b1;
    end

    assign smp_ready = grant_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_any_c) begin
            rr_ptr <= (gnt_idx_c == 3'(NCH - 1)) ? 3'd0 : 3'(gnt_idx_c + 3'd1);
        end
    end

    // Write pointers and saturating fill counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                wptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                wptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (grant_c[i]) begin
                    wptr[i] <= AW'(wptr[i] + 1'b1);
                    if (cnt[i] != CW'(DEPTH)) cnt[i] <= CW'(cnt[i] + 1'b1);
                end
            end
        end
    end

    // History storage; contents are don't-care until covered by cnt.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (grant_c[i]) mem[i][wptr[i]] <= smp_data[VAL_W*i +: VAL_W];
        end
    end

    // Column to storage index; a full buffer is read oldest-first from wptr.
    always_comb begin
        col_ok_c = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_idx_c[i]  = (cnt[i] == CW'(DEPTH)) ? AW'(wptr[i] + px_col) : px_col;
            col_ok_c[i]  = (cnt[i] == CW'(DEPTH)) || (CW'(px_col) < cnt[i]);
            rd_data_c[i] = mem[i][rd_idx_c[i]];
        end
    end

    // Lookup pipeline: stage 1 captures pre-write state, stage 2 compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_ok    <= '0;
            s1_row   <= '0;
            s2_vld   <= 1'b0;
            s2_hit   <= '0;
            px_valid <= 1'b0;
            px_code  <= '0;
            for (int i = 0; i < NCH; i++) s1_data[i] <= '0;
        end else begin
            s1_vld <= px_req;
            s1_ok  <= col_ok_c & ch_en;
            s1_row <= px_row;
            for (int i = 0; i < NCH; i++) s1_data[i] <= rd_data_c[i];
            s2_vld <= s1_vld;
            for (int i = 0; i < NCH; i++) s2_hit[i] <= s1_ok[i] & (s1_data[i] == s1_row);
            px_valid <= s2_vld;
            if (s2_vld) px_code <= s2_hit;
        end
    end

endmodule

// File: tb/tb_graph_trace_scheduler.sv
// Directed bench for graph_trace_scheduler: arbitration order, history wrap,
// freeze/clear, same-edge read/write ordering and reset mid-lookup.
module tb_graph_trace_scheduler;

    logic        clk;
    logic        rst_n;
    logic [4:0]  smp_valid;
    logic [39:0] smp_data;
    logic [4:0]  smp_ready;
    logic [4:0]  ch_en;
    logic        freeze;
    logic        clr;
    logic        px_req;
    logic [5:0]  px_col;
    logic [7:0]  px_row;
    logic        px_valid;
    logic [4:0]  px_code;

    int vectors;
    int miscompares;

    graph_trace_scheduler #(.DEPTH(64), .VAL_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .ch_en(ch_en), .freeze(freeze), .clr(clr),
        .px_req(px_req), .px_col(px_col), .px_row(px_row),
        .px_valid(px_valid), .px_code(px_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one sample on one channel for one cycle; called on a falling edge.
    task automatic put(input int ch, input logic [7:0] v);
        smp_valid = 5'(1 << ch);
        smp_data  = '0;
        smp_data[8*ch +: 8] = v;
        #1 chk("put_ready", 32'(smp_ready), 32'(1 << ch));
        @(negedge clk);
        smp_valid = '0;
    endtask

    // Single lookup with latency check; result is read after edge N+2.
    task automatic lookup(input string tag, input logic [5:0] col, input logic [7:0] row,
                          input logic [4:0] exp_code);
        px_req = 1'b1;
        px_col = col;
        px_row = row;
        @(negedge clk);
        px_req = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 32'(px_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(px_valid), 32'd1);
        chk({tag, "_code"}, 32'(px_code), 32'(exp_code));
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        smp_valid = 5'h1F;
        smp_data  = '0;
        ch_en     = 5'h1F;
        freeze    = 1'b0;
        clr       = 1'b0;
        px_req    = 1'b0;
        px_col    = '0;
        px_row    = '0;

        // Reset state with valids offered.
        #3;
        chk("rst_ready", 32'(smp_ready), 32'd0);
        chk("rst_pxvalid", 32'(px_valid), 32'd0);
        chk("rst_pxcode", 32'(px_code), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin order 0,1,2,3,4,0 with every channel requesting.
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_grant", 32'(smp_ready), 32'(1 << (k % 5)));
            @(negedge clk);
        end
        smp_valid = '0;

        // Clear blocks transfers and empties history.
        smp_valid = 5'h1F;
        clr = 1'b1;
        #1 chk("clr_ready", 32'(smp_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        smp_valid = '0;

        // Channel 1 partial fill.
        put(1, 8'd10);
        put(1, 8'd20);
        put(1, 8'd30);
        lookup("c1_col1", 6'd1, 8'd20, 5'b00010);
        lookup("c1_col0", 6'd0, 8'd10, 5'b00010);
        lookup("c1_col2", 6'd2, 8'd30, 5'b00010);
        lookup("c1_col3", 6'd3, 8'd0,  5'b00000);
        lookup("c1_wrongrow", 6'd1, 8'd10, 5'b00000);

        // Channel 0 wrap: 65 samples, oldest surviving value is 1.
        clear_pulse();
        for (int i = 0; i <= 64; i++) put(0, 8'(i));
        lookup("c0_oldest", 6'd0,  8'd1,  5'b00001);
        lookup("c0_newest", 6'd63, 8'd64, 5'b00001);
        lookup("c0_mid",    6'd10, 8'd11, 5'b00001);
        lookup("c0_row0a",  6'd0,  8'd0,  5'b00000);
        lookup("c0_row0b",  6'd63, 8'd0,  5'b00000);
        ch_en = 5'h1E;
        lookup("c0_masked", 6'd0, 8'd1, 5'b00000);
        ch_en = 5'h1F;
        lookup("c0_unmasked", 6'd0, 8'd1, 5'b00001);

        // Freeze holds history; clear then empties it.
        freeze = 1'b1;
        smp_valid = 5'h1F;
        for (int k = 0; k < 4; k++) begin
            #1 chk("freeze_ready", 32'(smp_ready), 32'd0);
            @(negedge clk);
        end
        freeze = 1'b0;
        smp_valid = '0;
        lookup("frz_oldest", 6'd0,  8'd1,  5'b00001);
        lookup("frz_newest", 6'd63, 8'd64, 5'b00001);
        clear_pulse();
        lookup("clr_oldest", 6'd0,  8'd1,  5'b00000);
        lookup("clr_newest", 6'd63, 8'd64, 5'b00000);
        lookup("clr_c1",     6'd1,  8'd20, 5'b00000);

        // Same-edge write and lookup on channel 2 index 5.
        for (int i = 1; i <= 5; i++) put(2, 8'(i));
        smp_valid = 5'b00100;
        smp_data  = '0;
        smp_data[23:16] = 8'd99;
        px_req = 1'b1;
        px_col = 6'd5;
        px_row = 8'd99;
        #1 chk("coll_ready", 32'(smp_ready), 32'b00100);
        @(negedge clk);
        smp_valid = '0;
        @(negedge clk);
        px_req = 1'b0;
        @(negedge clk);
        chk("coll_same_valid", 32'(px_valid), 32'd1);
        chk("coll_same_code", 32'(px_code), 32'b00000);
        @(negedge clk);
        chk("coll_next_valid", 32'(px_valid), 32'd1);
        chk("coll_next_code", 32'(px_code), 32'b00100);
        @(negedge clk);
        chk("hold_valid", 32'(px_valid), 32'd0);
        chk("hold_code", 32'(px_code), 32'b00100);

        // Back-to-back lookups with reset pulsed in cycle 3.
        for (int c = 0; c < 8; c++) begin
            px_req = 1'b1;
            px_col = 6'd5;
            px_row = 8'd99;
            if (c == 3) begin
                smp_valid = 5'h1F;
                #1 rst_n = 1'b0;
                #1;
                chk("mid_rst_valid", 32'(px_valid), 32'd0);
                chk("mid_rst_code", 32'(px_code), 32'd0);
                chk("mid_rst_ready", 32'(smp_ready), 32'd0);
            end
            if (c == 4) begin
                rst_n = 1'b1;
                smp_valid = '0;
            end
            if (c == 5 || c == 6) chk("post_rst_quiet", 32'(px_valid), 32'd0);
            if (c == 7) begin
                chk("post_rst_first_valid", 32'(px_valid), 32'd1);
                chk("post_rst_first_code", 32'(px_code), 32'd0);
            end
            @(negedge clk);
        end
        px_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("drain_valid", 32'(px_valid), 32'd0);
        chk("drain_code", 32'(px_code), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
